// File: rtl/opl_sched_pkg.sv
// Purpose: shared types and constants for the OPL write scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package opl_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT_A,
        ST_DATA,
        ST_WAIT_D
    } state_t;

    localparam int         OPL_ADDR_WAIT_DEF = 12;
    localparam int         OPL_DATA_WAIT_DEF = 84;
    localparam logic [2:0] NOTE_REG_HI       = 3'b101;

    // Registers 0xA0-0xBF carry F-number / key-on, i.e. note events.
    function automatic logic is_note_reg(input logic [7:0] r);
        return r[7:5] == NOTE_REG_HI;
    endfunction

endpackage

// File: rtl/opl_rr_arb2.sv
// Purpose: 2-way round-robin arbiter; a lone requester always wins, a tie goes to the port not granted last.
// Latency: grant is combinational from req; last_grant updates on the cycle after advance.
// Backpressure: none; the caller decides when a grant is consumed via advance.
module opl_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_grant;

    // One-hot grant; on a tie prefer the port that did not win last time.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Remember the winner of each consumed grant; reset to 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (advance) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/opl_write_scheduler.sv
// Purpose: arbitrates two {reg,val} requesters and sequences OPL address/data strobes with settling waits (OPL_SHADOW_EN adds a shadow register RAM).
// Latency: accept T, addr strobe T+1, data strobe T+2+ADDR_WAIT, next accept T+3+ADDR_WAIT+DATA_WAIT (cen=1).
// Backpressure: reqN_ready is only offered in IDLE to the granted port; requesters hold valid until accepted.
module opl_write_scheduler
    import opl_sched_pkg::*;
#(
    parameter int ADDR_WAIT = OPL_ADDR_WAIT_DEF,
    parameter int DATA_WAIT = OPL_DATA_WAIT_DEF,
    parameter int CW        = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       req0_valid,
    input  logic [7:0] req0_reg,
    input  logic [7:0] req0_val,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_reg,
    input  logic [7:0] req1_val,
    output logic       req1_ready,
    output logic       opl_cs_n,
    output logic       opl_wr_n,
    output logic       opl_addr,
    output logic [7:0] opl_din,
    output logic       busy,
    output logic       note_act
`ifdef OPL_SHADOW_EN
    ,
    input  logic [7:0] shadow_raddr,
    output logic [7:0] shadow_rdata
`endif
);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [7:0]    reg_q, val_q;
    logic [1:0]    grant;
    logic          xfer;
    logic          cs_n_nxt, wr_n_nxt, addr_nxt, busy_nxt, note_nxt;
    logic [7:0]    din_nxt;

    opl_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({req1_valid, req0_valid}),
        .advance (xfer),
        .grant   (grant)
    );

    // Readies are offered only while idle (and not while reset is held).
    assign req0_ready = rst_n & (state == ST_IDLE) & grant[0];
    assign req1_ready = rst_n & (state == ST_IDLE) & grant[1];
    assign xfer       = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    // Next state plus the next value of every registered OPL-side output.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cs_n_nxt  = 1'b1;
        wr_n_nxt  = 1'b1;
        addr_nxt  = opl_addr;
        din_nxt   = opl_din;
        busy_nxt  = busy;
        note_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    state_nxt = ST_ADDR;
                    busy_nxt  = 1'b1;
                    cs_n_nxt  = 1'b0;
                    wr_n_nxt  = 1'b0;
                    addr_nxt  = 1'b0;
                    din_nxt   = grant[1] ? req1_reg : req0_reg;
                end
            end
            ST_ADDR: begin
                if (cen) begin
                    if (ADDR_WAIT == 0) begin
                        state_nxt = ST_DATA;
                        cs_n_nxt  = 1'b0;
                        wr_n_nxt  = 1'b0;
                        addr_nxt  = 1'b1;
                        din_nxt   = val_q;
                    end else begin
                        state_nxt = ST_WAIT_A;
                        cnt_nxt   = CW'(ADDR_WAIT);
                    end
                end else begin
                    cs_n_nxt = 1'b0;
                    wr_n_nxt = 1'b0;
                end
            end
            ST_WAIT_A: begin
                if (cen) begin
                    if (cnt <= CW'(1)) begin
                        state_nxt = ST_DATA;
                        cnt_nxt   = '0;
                        cs_n_nxt  = 1'b0;
                        wr_n_nxt  = 1'b0;
                        addr_nxt  = 1'b1;
                        din_nxt   = val_q;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (cen) begin
                    note_nxt = is_note_reg(reg_q);
                    if (DATA_WAIT == 0) begin
                        state_nxt = ST_IDLE;
                        busy_nxt  = 1'b0;
                    end else begin
                        state_nxt = ST_WAIT_D;
                        cnt_nxt   = CW'(DATA_WAIT);
                    end
                end else begin
                    cs_n_nxt = 1'b0;
                    wr_n_nxt = 1'b0;
                end
            end
            ST_WAIT_D: begin
                if (cen) begin
                    if (cnt <= CW'(1)) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                        busy_nxt  = 1'b0;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State, counter, latched request and registered strobe outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            reg_q    <= 8'h00;
            val_q    <= 8'h00;
            opl_cs_n <= 1'b1;
            opl_wr_n <= 1'b1;
            opl_addr <= 1'b0;
            opl_din  <= 8'h00;
            busy     <= 1'b0;
            note_act <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            opl_cs_n <= cs_n_nxt;
            opl_wr_n <= wr_n_nxt;
            opl_addr <= addr_nxt;
            opl_din  <= din_nxt;
            busy     <= busy_nxt;
            note_act <= note_nxt;
            if (xfer) begin
                reg_q <= grant[1] ? req1_reg : req0_reg;
                val_q <= grant[1] ? req1_val : req0_val;
            end
        end
    end

`ifdef OPL_SHADOW_EN
    logic [7:0] shadow_mem [256];
    logic       shadow_we;

    assign shadow_we = (state == ST_DATA) & cen;

    // Shadow copy of every register value actually strobed into the chip.
    always_ff @(posedge clk) begin
        if (shadow_we) begin
            shadow_mem[reg_q] <= val_q;
        end
    end

    // Registered read port; a same-edge write is not visible until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_rdata <= 8'h00;
        end else begin
            shadow_rdata <= shadow_mem[shadow_raddr];
        end
    end
`endif

endmodule

// File: tb/tb_opl_write_scheduler.sv
// Purpose: directed self-checking bench for opl_write_scheduler (default waits and zero waits).
// Latency: checks are taken 1 time unit after the falling edge; inputs change on the falling edge.
// Backpressure: requesters hold valid until the bench sees ready.
module tb_opl_write_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cen;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_reg, req0_val, req1_reg, req1_val;
    logic       req0_ready, req1_ready;
    logic       opl_cs_n, opl_wr_n, opl_addr, busy, note_act;
    logic [7:0] opl_din;

    logic       z_cen;
    logic       z_req0_valid, z_req1_valid;
    logic [7:0] z_req0_reg, z_req0_val, z_req1_reg, z_req1_val;
    logic       z_req0_ready, z_req1_ready;
    logic       z_cs_n, z_wr_n, z_addr, z_busy, z_note;
    logic [7:0] z_din;

`ifdef OPL_SHADOW_EN
    logic [7:0] shadow_raddr, shadow_rdata, z_shadow_raddr, z_shadow_rdata;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    opl_write_scheduler dut (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_val(req0_val), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_val(req1_val), .req1_ready(req1_ready),
        .opl_cs_n(opl_cs_n), .opl_wr_n(opl_wr_n), .opl_addr(opl_addr), .opl_din(opl_din),
        .busy(busy), .note_act(note_act)
`ifdef OPL_SHADOW_EN
        , .shadow_raddr(shadow_raddr), .shadow_rdata(shadow_rdata)
`endif
    );

    opl_write_scheduler #(.ADDR_WAIT(0), .DATA_WAIT(0), .CW(7)) dut_z (
        .clk(clk), .rst_n(rst_n), .cen(z_cen),
        .req0_valid(z_req0_valid), .req0_reg(z_req0_reg), .req0_val(z_req0_val), .req0_ready(z_req0_ready),
        .req1_valid(z_req1_valid), .req1_reg(z_req1_reg), .req1_val(z_req1_val), .req1_ready(z_req1_ready),
        .opl_cs_n(z_cs_n), .opl_wr_n(z_wr_n), .opl_addr(z_addr), .opl_din(z_din),
        .busy(z_busy), .note_act(z_note)
`ifdef OPL_SHADOW_EN
        , .shadow_raddr(z_shadow_raddr), .shadow_rdata(z_shadow_rdata)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400 && busy; i++) @(negedge clk);
        #1;
        chk(tag, busy, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int ng, na, nd, both;
        int gport[4], gcyc[4], sa[4], sd[4], dd[4];
        int a_first, a_str, d_str, d_din, alow, dlow, notes, lowcnt;

        rst_n = 1'b0; cen = 1'b1; z_cen = 1'b1;
        req0_valid = 0; req0_reg = 0; req0_val = 0;
        req1_valid = 0; req1_reg = 0; req1_val = 0;
        z_req0_valid = 0; z_req0_reg = 0; z_req0_val = 0;
        z_req1_valid = 0; z_req1_reg = 0; z_req1_val = 0;
`ifdef OPL_SHADOW_EN
        shadow_raddr = 0; z_shadow_raddr = 0;
`endif
        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cs_n", opl_cs_n, 1);
        chk("rst_wr_n", opl_wr_n, 1);
        chk("rst_addr", opl_addr, 0);
        chk("rst_din", opl_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_note", note_act, 0);
        req0_valid = 1; req1_valid = 1;
        #1;
        chk("rst_rdy0", req0_ready, 0);
        chk("rst_rdy1", req1_ready, 0);
        req0_valid = 0; req1_valid = 0;
        rst_n = 1'b1;
        @(negedge clk);

        // Single write to a note register, T = this cycle
        @(negedge clk);
        req0_valid = 1; req0_reg = 8'hA0; req0_val = 8'h44;
        #1;
        chk("t2_rdy0_T", req0_ready, 1);
        chk("t2_rdy1_T", req1_ready, 0);
        @(negedge clk); req0_valid = 0; #1;
        chk("t2_cs_n_T1", opl_cs_n, 0);
        chk("t2_wr_n_T1", opl_wr_n, 0);
        chk("t2_addr_T1", opl_addr, 0);
        chk("t2_din_T1", opl_din, 8'hA0);
        chk("t2_busy_T1", busy, 1);
        repeat (12) @(negedge clk); #1;
        chk("t2_cs_n_T13", opl_cs_n, 1);
        @(negedge clk); #1;
        chk("t2_cs_n_T14", opl_cs_n, 0);
        chk("t2_wr_n_T14", opl_wr_n, 0);
        chk("t2_addr_T14", opl_addr, 1);
        chk("t2_din_T14", opl_din, 8'h44);
        @(negedge clk); #1;
        chk("t2_note_T15", note_act, 1);
        chk("t2_cs_n_T15", opl_cs_n, 1);
        @(negedge clk); #1;
        chk("t2_note_T16", note_act, 0);
        repeat (82) @(negedge clk);
        req0_valid = 1; #1;
        chk("t2_busy_T98", busy, 1);
        chk("t2_rdy0_T98", req0_ready, 0);
        @(negedge clk); #1;
        chk("t2_busy_T99", busy, 0);
        chk("t2_rdy0_T99", req0_ready, 1);
        req0_valid = 0;

        // Reset in the middle of the data wait
        @(negedge clk);
        req1_valid = 1; req1_reg = 8'h40; req1_val = 8'h3F; #1;
        chk("t1_rdy1", req1_ready, 1);
        @(negedge clk); req1_valid = 0;
        repeat (30) @(negedge clk); #1;
        chk("t1_busy_pre", busy, 1);
        rst_n = 1'b0; #1;
        chk("t1_cs_n", opl_cs_n, 1);
        chk("t1_wr_n", opl_wr_n, 1);
        chk("t1_addr", opl_addr, 0);
        chk("t1_din", opl_din, 0);
        chk("t1_busy", busy, 0);
        chk("t1_note", note_act, 0);
        @(negedge clk); rst_n = 1'b1;
        lowcnt = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!opl_cs_n || !opl_wr_n) lowcnt++;
            @(negedge clk);
        end
        chk("t1_no_strobe", lowcnt, 0);
        chk("t1_busy_post", busy, 0);

        // Both ports requesting continuously
        req0_valid = 1; req0_reg = 8'h20; req0_val = 8'h11;
        req1_valid = 1; req1_reg = 8'hB0; req1_val = 8'h22;
        ng = 0; na = 0; nd = 0; both = 0;
        for (int i = 0; i < 4; i++) begin gport[i] = -1; gcyc[i] = 0; sa[i] = 0; sd[i] = 0; dd[i] = 0; end
        for (int c = 0; c < 450 && nd < 4; c++) begin
            if (ng == 4) begin req0_valid = 0; req1_valid = 0; end
            #1;
            if (req0_ready && req1_ready) both++;
            if (ng < 4 && (req0_ready || req1_ready)) begin
                gport[ng] = req1_ready ? 1 : 0; gcyc[ng] = c; ng++;
            end
            if (!opl_cs_n) begin
                if (!opl_addr) begin
                    if (na < 4) sa[na] = c;
                    na++;
                end else begin
                    if (nd < 4) begin sd[nd] = c; dd[nd] = opl_din; end
                    nd++;
                end
            end
            @(negedge clk);
        end
        req0_valid = 0; req1_valid = 0;
        chk("t3_ngrants", ng, 4);
        chk("t3_ndata", nd, 4);
        chk("t3_both_ready", both, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_port%0d", i), gport[i], i % 2);
            chk($sformatf("t3_din%0d", i), dd[i], (i % 2) ? 32'h22 : 32'h11);
            chk($sformatf("t3_a2d%0d", i), sd[i] - sa[i], 13);
            chk($sformatf("t3_acc2a%0d", i), sa[i] - gcyc[i], 1);
            if (i > 0) begin
                chk($sformatf("t3_accgap%0d", i), gcyc[i] - gcyc[i-1], 99);
                chk($sformatf("t3_d2a_ge85_%0d", i), (sa[i] - sd[i-1]) >= 85, 1);
            end
        end
        wait_idle("t3_idle");

        // cen high one cycle in four
        a_first = -1; a_str = -1; d_str = -1; d_din = -1; alow = 0; dlow = 0; notes = 0;
        for (int c = 0; c < 400; c++) begin
            cen = ((c % 4) == 3);
            if (c == 0) begin req0_valid = 1; req0_reg = 8'h60; req0_val = 8'h55; end
            if (c == 1) req0_valid = 0;
            #1;
            if (c == 0) chk("t4_rdy0", req0_ready, 1);
            if (!opl_cs_n && !opl_addr) begin
                alow++;
                if (a_first < 0) a_first = c;
                if (cen && a_str < 0) a_str = c;
            end
            if (!opl_cs_n && opl_addr) begin
                dlow++;
                if (cen && d_str < 0) begin d_str = c; d_din = opl_din; end
            end
            if (note_act) notes++;
            @(negedge clk);
        end
        cen = 1'b1;
        chk("t4_addr_first", a_first, 1);
        chk("t4_addr_strobe", a_str, 3);
        chk("t4_addr_held", alow, 3);
        chk("t4_a2d", d_str - a_str, 52);
        chk("t4_data_held", dlow, 4);
        chk("t4_din", d_din, 8'h55);
        chk("t4_no_note", notes, 0);
        wait_idle("t4_idle");

        // Zero-wait instance
        @(negedge clk);
        z_req0_valid = 1; z_req0_reg = 8'hB5; z_req0_val = 8'h7E; #1;
        chk("t5_rdy_T", z_req0_ready, 1);
        @(negedge clk); z_req0_valid = 0; #1;
        chk("t5_cs_n_T1", z_cs_n, 0);
        chk("t5_addr_T1", z_addr, 0);
        chk("t5_din_T1", z_din, 8'hB5);
        @(negedge clk); #1;
        chk("t5_cs_n_T2", z_cs_n, 0);
        chk("t5_addr_T2", z_addr, 1);
        chk("t5_din_T2", z_din, 8'h7E);
        @(negedge clk);
        z_req0_valid = 1; #1;
        chk("t5_cs_n_T3", z_cs_n, 1);
        chk("t5_busy_T3", z_busy, 0);
        chk("t5_note_T3", z_note, 1);
        chk("t5_rdy_T3", z_req0_ready, 1);
        z_req0_valid = 0;

`ifdef OPL_SHADOW_EN
        // Shadow RAM: same-edge read gives old 0x11 (from the arbitration test), then 0x01
        @(negedge clk);
        req0_valid = 1; req0_reg = 8'h20; req0_val = 8'h01;
        @(negedge clk); req0_valid = 0;
        repeat (13) @(negedge clk);
        shadow_raddr = 8'h20; #1;
        chk("t6_data_strobe", opl_cs_n, 0);
        @(negedge clk); #1;
        chk("t6_rdata_old", shadow_rdata, 8'h11);
        @(negedge clk); #1;
        chk("t6_rdata_new", shadow_rdata, 8'h01);
        wait_idle("t6_idle");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
